// File: rtl/led_pkg.sv
// Shared types and constants for the LED brightness engine.
package led_pkg;

    localparam int unsigned PWM_BITS_DEF = 8;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } ramp_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM generator: free-running counter, duty captured at period end, registered compare.
module led_pwm
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;

    // Duty only changes on the last count so every period is whole.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_cnt <= '0;
            duty    <= '0;
            o_pwm   <= 1'b0;
        end else if (!i_en) begin
            pwm_cnt <= '0;
            o_pwm   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == '1) begin
                duty <= i_duty;
            end
            o_pwm <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/led_breather.sv
// LED brightness engine: off / on / blink / breathe, driven by the divider tick.
module led_breather
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
    parameter int unsigned HOLD_TICKS  = 16,
    parameter int unsigned BLINK_TICKS = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_tick,
    input  logic [1:0]          i_mode,
    input  logic [PWM_BITS-1:0] i_max_level,
    output logic                o_led,
    output logic [PWM_BITS-1:0] o_level,
    output logic [1:0]          o_state
);

    localparam int unsigned HOLD_W  = cnt_width(HOLD_TICKS);
    localparam int unsigned BLINK_W = cnt_width(BLINK_TICKS);

    mode_t               mode;
    ramp_state_t         state;
    logic [PWM_BITS-1:0] level;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_ph;
    logic [PWM_BITS-1:0] duty_src_c;

    assign mode    = mode_t'(i_mode);
    assign o_level = level;
    assign o_state = state;

    // Duty source mux; the PWM samples it only at its period boundary.
    always_comb begin
        duty_src_c = '0;
        case (mode)
            MODE_ON:      duty_src_c = i_max_level;
            MODE_BLINK:   duty_src_c = blink_ph ? i_max_level : '0;
            MODE_BREATHE: duty_src_c = level;
            default:      duty_src_c = '0;
        endcase
    end

    // Blink half-period counter; parked at zero outside BLINK.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (i_en) begin
            if (mode != MODE_BLINK) begin
                blink_cnt <= '0;
                blink_ph  <= 1'b0;
            end else if (i_tick) begin
                if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    // Triangle ramp with holds; a lowered ceiling clamps level on the next tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= RISE;
            level    <= '0;
            hold_cnt <= '0;
        end else if (i_en) begin
            if (mode != MODE_BREATHE) begin
                state    <= RISE;
                level    <= '0;
                hold_cnt <= '0;
            end else if (i_tick) begin
                case (state)
                    RISE: begin
                        if (level >= i_max_level) begin
                            level    <= i_max_level;
                            hold_cnt <= '0;
                            state    <= HOLD_HI;
                        end else begin
                            level <= level + PWM_BITS'(1);
                        end
                    end
                    HOLD_HI, HOLD_LO: begin
                        if (level > i_max_level) begin
                            level <= i_max_level;
                        end
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            hold_cnt <= '0;
                            state    <= (state == HOLD_HI) ? FALL : RISE;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    FALL: begin
                        if (level > i_max_level) begin
                            level <= i_max_level;
                        end else if (level == '0) begin
                            hold_cnt <= '0;
                            state    <= HOLD_LO;
                        end else begin
                            level <= level - PWM_BITS'(1);
                        end
                    end
                    default: state <= RISE;
                endcase
            end
        end
    end

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_duty  (duty_src_c),
        .o_pwm   (o_led)
    );

endmodule
